// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: owns the fetch PC, resolves branches/jumps from execute,
// and holds a registered flush for FLUSH_CYCLES cycles after each taken redirect.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken counters
// on TAKEN_CNT / NOT_TAKEN_CNT. Without the macro those ports do not exist.
module branch_redirect_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int unsigned     FLUSH_CYCLES = 2
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            STALL,
   input  logic            BR_VALID,
   input  logic            JUMP,
   input  logic            JALR,
   input  logic [2:0]      FUNCT3,
   input  logic            EQ,
   input  logic            LT,
   input  logic            LTU,
   input  logic [XLEN-1:0] PC_EX,
   input  logic [XLEN-1:0] IMM,
   input  logic [XLEN-1:0] RS1,
   output logic [XLEN-1:0] PC,
   output logic            FLUSH,
   output logic            BR_TAKEN,
   output logic            MISALIGN
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]     TAKEN_CNT,
   output logic [15:0]     NOT_TAKEN_CNT
`endif
);

   typedef enum logic {StRun, StFlush} state_e;

   // Counter loads FLUSH_CYCLES-1 so FLUSH stays high for exactly FLUSH_CYCLES cycles.
   localparam logic [1:0] CntInit = 2'(FLUSH_CYCLES - 1);

   state_e          state_q;
   logic [1:0]      cnt_q;
   logic [XLEN-1:0] pc_q;
   logic            flush_q;
   logic            br_taken_q;
   logic            misalign_q;

   logic            cond;
   logic            in_run;
   logic            take;
   logic            redirect;
   logic            misaligned;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_inc;

   // Branch condition decode; unused encodings are never taken.
   always_comb begin
      cond = 1'b0;
      case (FUNCT3)
         3'b000:  cond = EQ;
         3'b001:  cond = ~EQ;
         3'b100:  cond = LT;
         3'b101:  cond = ~LT;
         3'b110:  cond = LTU;
         3'b111:  cond = ~LTU;
         default: cond = 1'b0;
      endcase
   end

   // Target selection and take/misalign qualification; wrap-around is silent.
   always_comb begin
      jalr_sum   = RS1 + IMM;
      target     = PC_EX + IMM;
      if (JUMP && JALR) begin
         target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      in_run     = (state_q == StRun);
      // Instructions in execute during a flush are wrong-path, so only RUN may take.
      take       = BR_VALID & in_run & (JUMP | cond);
      misaligned = take & target[1];
      redirect   = take & ~target[1];
      pc_inc     = pc_q + XLEN'(4);
   end

   // PC/flush FSM with registered outputs; redirect beats STALL, STALL beats increment.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= StRun;
         cnt_q      <= 2'd0;
         pc_q       <= RESET_PC;
         flush_q    <= 1'b0;
         br_taken_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         br_taken_q <= redirect;
         misalign_q <= misaligned;
         case (state_q)
            StRun: begin
               if (redirect) begin
                  pc_q    <= target;
                  cnt_q   <= CntInit;
                  state_q <= StFlush;
                  flush_q <= 1'b1;
               end else if (!STALL) begin
                  pc_q <= pc_inc;
               end
            end
            StFlush: begin
               if (!STALL) begin
                  pc_q <= pc_inc;
               end
               if (cnt_q == 2'd0) begin
                  state_q <= StRun;
                  flush_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
         endcase
      end
   end

   assign PC       = pc_q;
   assign FLUSH    = flush_q;
   assign BR_TAKEN = br_taken_q;
   assign MISALIGN = misalign_q;

`ifdef BRANCH_STATS_EN
   logic [15:0] taken_cnt_q;
   logic [15:0] not_taken_cnt_q;
   logic        not_taken_ev;

   // A resolved conditional branch in RUN whose condition is false.
   assign not_taken_ev = BR_VALID & in_run & ~JUMP & ~cond;

   // Saturating statistics counters.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         taken_cnt_q     <= 16'd0;
         not_taken_cnt_q <= 16'd0;
      end else begin
         if (redirect && (taken_cnt_q != 16'hFFFF)) begin
            taken_cnt_q <= taken_cnt_q + 16'd1;
         end
         if (not_taken_ev && (not_taken_cnt_q != 16'hFFFF)) begin
            not_taken_cnt_q <= not_taken_cnt_q + 16'd1;
         end
      end
   end

   assign TAKEN_CNT     = taken_cnt_q;
   assign NOT_TAKEN_CNT = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed self-checking bench for branch_redirect_unit (default parameters).
module tb_branch_redirect_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        br_valid;
   logic        jump;
   logic        jalr;
   logic [2:0]  funct3;
   logic        eq;
   logic        lt;
   logic        ltu;
   logic [31:0] pc_ex;
   logic [31:0] imm;
   logic [31:0] rs1;
   logic [31:0] pc;
   logic        flush;
   logic        br_taken;
   logic        misalign;
`ifdef BRANCH_STATS_EN
   logic [15:0] taken_cnt;
   logic [15:0] not_taken_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   branch_redirect_unit dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .STALL    (stall),
      .BR_VALID (br_valid),
      .JUMP     (jump),
      .JALR     (jalr),
      .FUNCT3   (funct3),
      .EQ       (eq),
      .LT       (lt),
      .LTU      (ltu),
      .PC_EX    (pc_ex),
      .IMM      (imm),
      .RS1      (rs1),
      .PC       (pc),
      .FLUSH    (flush),
      .BR_TAKEN (br_taken),
      .MISALIGN (misalign)
`ifdef BRANCH_STATS_EN
      ,
      .TAKEN_CNT     (taken_cnt),
      .NOT_TAKEN_CNT (not_taken_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge, then sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_br(input logic v, input logic j, input logic jr, input logic [2:0] f3,
                         input logic [31:0] pe, input logic [31:0] im, input logic [31:0] r1);
      br_valid = v;
      jump     = j;
      jalr     = jr;
      funct3   = f3;
      pc_ex    = pe;
      imm      = im;
      rs1      = r1;
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      eq    = 1'b0;
      lt    = 1'b0;
      ltu   = 1'b0;
      set_br(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);

      // Reset state
      tick();
      tick();
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_flush", {31'b0, flush}, 32'h0);
      check_eq("rst_taken", {31'b0, br_taken}, 32'h0);
      check_eq("rst_misalign", {31'b0, misalign}, 32'h0);
`ifdef BRANCH_STATS_EN
      check_eq("rst_taken_cnt", {16'b0, taken_cnt}, 32'h0);
      check_eq("rst_not_taken_cnt", {16'b0, not_taken_cnt}, 32'h0);
`endif
      rst_n = 1'b1;
      check_eq("rel_pc0", pc, 32'h0);
      tick(); check_eq("seq_pc4", pc, 32'h4);
      tick(); check_eq("seq_pc8", pc, 32'h8);
      tick(); check_eq("seq_pc12", pc, 32'hC);
      check_eq("seq_flush", {31'b0, flush}, 32'h0);

      // BEQ taken: 0x100 + 0x40
      eq = 1'b1;
      set_br(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h40, 32'h0);
      tick();
      check_eq("beq_pc", pc, 32'h140);
      check_eq("beq_taken", {31'b0, br_taken}, 32'h1);
      check_eq("beq_flush1", {31'b0, flush}, 32'h1);
      // Keep a taken BEQ valid through the flush: ignored, then honoured in RUN.
      set_br(1'b1, 1'b0, 1'b0, 3'b000, 32'h200, 32'h0, 32'h0);
      tick();
      check_eq("fl_pc1", pc, 32'h144);
      check_eq("fl_flush2", {31'b0, flush}, 32'h1);
      check_eq("fl_taken_pulse", {31'b0, br_taken}, 32'h0);
      tick();
      check_eq("fl_pc2", pc, 32'h148);
      check_eq("fl_flush_end", {31'b0, flush}, 32'h0);
      check_eq("fl_ignored", {31'b0, br_taken}, 32'h0);
      tick();
      check_eq("b2b_pc", pc, 32'h200);
      check_eq("b2b_taken", {31'b0, br_taken}, 32'h1);
      set_br(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      tick();
      check_eq("b2b_pc1", pc, 32'h204);
      tick();
      check_eq("b2b_pc2", pc, 32'h208);
      check_eq("b2b_flush_end", {31'b0, flush}, 32'h0);

      // BNE with EQ=1: not taken
      set_br(1'b1, 1'b0, 1'b0, 3'b001, 32'h300, 32'h10, 32'h0);
      tick();
      check_eq("bne_pc", pc, 32'h20C);
      check_eq("bne_taken", {31'b0, br_taken}, 32'h0);
      check_eq("bne_flush", {31'b0, flush}, 32'h0);

      // BGEU with LTU=0: taken, target wraps
      ltu = 1'b0;
      set_br(1'b1, 1'b0, 1'b0, 3'b111, 32'hFFFF_FFF0, 32'h20, 32'h0);
      tick();
      check_eq("bgeu_pc", pc, 32'h10);
      check_eq("bgeu_taken", {31'b0, br_taken}, 32'h1);
      set_br(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      tick();
      tick();
      check_eq("bgeu_pc2", pc, 32'h18);
      check_eq("bgeu_flush_end", {31'b0, flush}, 32'h0);

      // JALR: (0x201 + 4) & ~1 = 0x204
      set_br(1'b1, 1'b1, 1'b1, 3'b010, 32'h0, 32'h4, 32'h201);
      tick();
      check_eq("jalr_pc", pc, 32'h204);
      check_eq("jalr_taken", {31'b0, br_taken}, 32'h1);
      set_br(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      tick();
      tick();
      check_eq("jalr_pc2", pc, 32'h20C);

      // JAL to 0x6: bit 1 set, suppressed
      set_br(1'b1, 1'b1, 1'b0, 3'b000, 32'h0, 32'h6, 32'h0);
      tick();
      check_eq("jal_mis_pc", pc, 32'h210);
      check_eq("jal_mis_pulse", {31'b0, misalign}, 32'h1);
      check_eq("jal_mis_flush", {31'b0, flush}, 32'h0);
      check_eq("jal_mis_taken", {31'b0, br_taken}, 32'h0);
      set_br(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      tick();
      check_eq("jal_mis_clear", {31'b0, misalign}, 32'h0);
      check_eq("jal_mis_pc2", pc, 32'h214);

      // JALR to 0x203 & ~1 = 0x202: bit 1 set, suppressed
      set_br(1'b1, 1'b1, 1'b1, 3'b000, 32'h0, 32'h0, 32'h203);
      tick();
      check_eq("jalr_mis_pc", pc, 32'h218);
      check_eq("jalr_mis_pulse", {31'b0, misalign}, 32'h1);
      set_br(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);

      // STALL with taken BLT: redirect wins (0x400 - 8)
      stall = 1'b1;
      lt    = 1'b1;
      set_br(1'b1, 1'b0, 1'b0, 3'b100, 32'h400, 32'hFFFF_FFF8, 32'h0);
      tick();
      check_eq("blt_stall_pc", pc, 32'h3F8);
      check_eq("blt_stall_taken", {31'b0, br_taken}, 32'h1);
      set_br(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      tick();
      check_eq("stall_fl_pc", pc, 32'h3F8);
      tick();
      check_eq("stall_fl_end", {31'b0, flush}, 32'h0);
      tick();
      check_eq("stall_hold_pc", pc, 32'h3F8);
      stall = 1'b0;

      // FUNCT3=010 with every flag set: never taken
      eq  = 1'b1;
      lt  = 1'b1;
      ltu = 1'b1;
      set_br(1'b1, 1'b0, 1'b0, 3'b010, 32'h800, 32'h100, 32'h0);
      tick();
      check_eq("f3_010_pc", pc, 32'h3FC);
      check_eq("f3_010_taken", {31'b0, br_taken}, 32'h0);

      // BGE with LT=1: not taken
      set_br(1'b1, 1'b0, 1'b0, 3'b101, 32'h800, 32'h100, 32'h0);
      tick();
      check_eq("bge_nt_pc", pc, 32'h400);

      // Asynchronous reset mid-flush
      set_br(1'b1, 1'b0, 1'b0, 3'b000, 32'h500, 32'h0, 32'h0);
      tick();
      check_eq("mid_pre_pc", pc, 32'h500);
      check_eq("mid_pre_flush", {31'b0, flush}, 32'h1);
      set_br(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_pc", pc, 32'h0);
      check_eq("mid_rst_flush", {31'b0, flush}, 32'h0);
      #2;
      rst_n = 1'b1;
      tick();
      check_eq("mid_rel_pc", pc, 32'h4);
      check_eq("mid_rel_flush", {31'b0, flush}, 32'h0);

`ifdef BRANCH_STATS_EN
      // Three taken, two not-taken, spaced past each flush
      for (int i = 0; i < 3; i++) begin
         eq = 1'b1;
         set_br(1'b1, 1'b0, 1'b0, 3'b000, 32'h600, 32'h0, 32'h0);
         tick();
         set_br(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
         tick();
         tick();
         if (i < 2) begin
            set_br(1'b1, 1'b0, 1'b0, 3'b001, 32'h600, 32'h0, 32'h0);
            tick();
            set_br(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
         end
      end
      check_eq("stats_taken", {16'b0, taken_cnt}, 32'd3);
      check_eq("stats_not_taken", {16'b0, not_taken_cnt}, 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
